// File: rtl/rgb_capture.sv
// rgb_capture: samples a parallel RGB565 LCD bus in the clk domain,
// recovers pixel coordinates and checks line/frame geometry.
module rgb_capture #(
    parameter int H_ACTIVE        = 480,
    parameter int V_ACTIVE        = 272,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pclk,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    input  logic [15:0] color,
    output logic        pixel_valid,
    output logic [8:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic [15:0] pixel_color,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic [15:0] frame_count
);

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        FRAME     = 1'b1
    } state_t;

    localparam logic [8:0] H_LIM = 9'(H_ACTIVE);
    localparam logic [8:0] V_LIM = 9'(V_ACTIVE);
    localparam logic [8:0] C_MAX = 9'h1FF;

    state_t      state_q, state_d;
    logic        pclk_q, pclk_d;
    logic        vs_prev_q, vs_prev_d;
    logic        de_prev_q, de_prev_d;
    logic        hs_q, hs_d;
    logic [8:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic [8:0]  pixel_x_q, pixel_x_d;
    logic [8:0]  pixel_y_q, pixel_y_d;
    logic [15:0] pixel_color_q, pixel_color_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic strobe;
    logic vs_n;
    logic hs_n;
    logic vs_lead;
    logic de_fall;

    function automatic logic [8:0] sat_inc(input logic [8:0] v);
        return (v == C_MAX) ? v : v + 9'd1;
    endfunction

    // Syncs are normalised to active-high before any edge detection.
    assign strobe  = pclk & ~pclk_q;
    assign vs_n    = SYNC_ACTIVE_LOW ? ~vsync : vsync;
    assign hs_n    = SYNC_ACTIVE_LOW ? ~hsync : hsync;
    assign vs_lead = vs_n & ~vs_prev_q;
    assign de_fall = ~de & de_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SYNC_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SYNC_WAIT: if (strobe && vs_lead) state_d = FRAME;
            FRAME:     state_d = FRAME;
        endcase
    end

    always_comb begin
        pclk_d        = pclk;
        vs_prev_d     = strobe ? vs_n : vs_prev_q;
        de_prev_d     = strobe ? de : de_prev_q;
        hs_d          = strobe ? hs_n : hs_q;
        x_d           = x_q;
        y_d           = y_q;
        pixel_valid_d = 1'b0;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        pixel_color_d = pixel_color_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = 1'b0;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        if (strobe) begin
            unique case (state_q)
                SYNC_WAIT: begin
                    if (vs_lead) begin
                        frame_start_d = 1'b1;
                        x_d           = 9'd0;
                        y_d           = 9'd0;
                    end
                end
                FRAME: begin
                    if (de_fall) begin
                        line_err_d = (x_q != H_LIM);
                        y_d        = sat_inc(y_q);
                        x_d        = 9'd0;
                    end
                    // y_d already includes a line closed on this sample.
                    if (vs_lead) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        frame_err_d   = (y_d != V_LIM);
                        frame_start_d = 1'b1;
                        x_d           = 9'd0;
                        y_d           = 9'd0;
                    end
                    if (de) begin
                        if (x_d < H_LIM && y_d < V_LIM) begin
                            pixel_valid_d = 1'b1;
                            pixel_x_d     = x_d;
                            pixel_y_d     = y_d;
                            pixel_color_d = color;
                        end
                        x_d = sat_inc(x_d);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pclk_q        <= 1'b1;
            vs_prev_q     <= 1'b0;
            de_prev_q     <= 1'b0;
            hs_q          <= 1'b0;
            x_q           <= 9'd0;
            y_q           <= 9'd0;
            pixel_valid_q <= 1'b0;
            pixel_x_q     <= 9'd0;
            pixel_y_q     <= 9'd0;
            pixel_color_q <= 16'd0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            pclk_q        <= pclk_d;
            vs_prev_q     <= vs_prev_d;
            de_prev_q     <= de_prev_d;
            hs_q          <= hs_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pixel_color_q <= pixel_color_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pixel_valid = pixel_valid_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign pixel_color = pixel_color_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/rgb_capture.md
# rgb_capture

Receive-side counterpart of the parallel RGB565 LCD interface (pclk, hsync, vsync, de, color[15:0]) produced by the display timing generator. It samples the interface in the system clock domain, recovers pixel coordinates, emits one strobe per active pixel and checks frame geometry against the configured panel size. It serves two roles: a self-checking monitor in display benches, and a frame-grabber front end for on-chip readback.

## Interface

Parameters:
- H_ACTIVE, 480: active pixels per line.
- V_ACTIVE, 272: active lines per frame.
- SYNC_ACTIVE_LOW, 1: 1 means hsync/vsync are asserted low; 0 means asserted high.

Ports:
- clk  in  1  system clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- pclk  in  1  pixel clock, a divided copy of clk, sampled as data.
- hsync  in  1  line sync; polarity set by SYNC_ACTIVE_LOW.
- vsync  in  1  frame sync; polarity set by SYNC_ACTIVE_LOW.
- de  in  1  data enable, active high.
- color  in  16  RGB565 pixel value.
- pixel_valid  out  1  one-clk strobe per accepted pixel.
- pixel_x  out  9  column of the accepted pixel.
- pixel_y  out  9  row of the accepted pixel.
- pixel_color  out  16  color of the accepted pixel.
- frame_start  out  1  one-clk pulse on each vsync leading edge.
- frame_done  out  1  one-clk pulse when a locked frame ends.
- line_err  out  1  one-clk pulse when a line's de run is not exactly H_ACTIVE samples.
- frame_err  out  1  one-clk pulse when a frame does not contain exactly V_ACTIVE lines.
- frame_count  out  16  number of completed frames; wraps 0xFFFF→0.

## Operation

- **pclk edge detect:** register pclk into pclk_q each clk. The sample strobe is `pclk & !pclk_q`. On a strobe cycle, hsync, vsync, de and color are captured. The source changes these on pclk falling edges; the sink samples them on pclk rising edges.
- **Previous-sample tracking:** the previous sampled vsync and de values are kept. Sync levels are normalised to active-high using SYNC_ACTIVE_LOW.
- **States:**
  - SYNC_WAIT: entered on reset. All de activity is ignored. A vsync leading edge moves to FRAME, pulses frame_start and sets x=0, y=0. No frame_done is issued.
  - FRAME: locked and counting.
- **Event order within one sample (FRAME state):**
  1. **de falling edge (line end):** pulse line_err if x≠H_ACTIVE. Then y←y+1, saturating at 511. Then x←0.
  2. **vsync leading edge (frame end):**
     - pulse frame_done;
     - increment frame_count;
     - pulse frame_err if y≠V_ACTIVE, where y includes a line ended in step 1 of the same sample;
     - then pulse frame_start and set x=0, y=0.
  3. **de high:** if x<H_ACTIVE and y<V_ACTIVE, pulse pixel_valid with pixel_x=x, pixel_y=y and pixel_color=color. In all cases x←x+1, saturating at 511. Out-of-range pixels are dropped silently; the error is reported at line end or frame end.
- **hsync:** has no effect on counters, since de alone delimits lines. It is sampled for future porch checks only.
- **Status outputs:** pixel_x, pixel_y and pixel_color hold their last value between strobes.

## Timing

- **Reset values:**
  - all pulse outputs 0; pixel_x, pixel_y, pixel_color, frame_count all 0;
  - state SYNC_WAIT;
  - pclk_q=1, so a pclk that is already high at reset release does not produce a false edge;
  - previous vsync/de = inactive.
- **Latency:** every output updates on the clk edge that follows the strobe cycle, i.e. one clk after pclk rising is seen. Pulses are exactly one clk wide.
- **pclk constraints:** pclk must be high for at least 1 clk and low for at least 1 clk. A pclk period of at least 2 clk guarantees at most one strobe per pclk period.
- **Reset mid-frame:** the block returns to SYNC_WAIT. The remainder of the current frame produces no pixels and no errors, and capture resumes at the next vsync leading edge.
- **Simultaneous events** follow the ordering in Operation:
  - de falling and vsync leading on the same sample: line_err, frame_done, frame_err and frame_start may all pulse in the same clk.
  - vsync leading and de high on the same sample: the pixel is emitted as (0,0).

## Test plan

- **Nominal frames:** pclk = clk/4, with 2 nominal 480×272 frames after reset. Required: 130560 pixel_valid per frame; first pixel (0,0), last (479,271); frame_start ×3, frame_done ×2, frame_count=2; no line_err or frame_err.
- **Short line:** line 5 carries 479 de samples. Required: one line_err at the end of line 5; (479,5) is never emitted; frame_err=0.
- **Extra lines:** a frame has 273 active lines. Required: line 272 produces no pixel_valid, and frame_err pulses in the same clk as frame_done.
- **Startup and mid-frame reset:** de activity before the first vsync, then reset asserted mid-frame at line 100. Required: zero pixel_valid until the next vsync leading edge; frame_count=0 after reset; no errors on resume.
- **Coincident edges:** de falls on the same sample as the vsync leading edge at the end of line 271. Required: line_err=0, frame_done=1, frame_err=0 and frame_start=1, all in one clk.
- **Polarity and wrap:** SYNC_ACTIVE_LOW=0 with inverted syncs gives identical results to the nominal frames case. Forcing frame_count to 0xFFFF then completing one frame gives frame_count=0.
